// File: rtl/core_sequencer_if.sv
// rtl/core_sequencer_if.sv - datapath/memory handshake bundle for the core sequencer
interface core_sequencer_if #(
  parameter int CNT_WIDTH = 32
);
  logic                 mem_ready;
  logic                 dec_illegal;
  logic                 dec_load;
  logic                 dec_store;
  logic                 dec_has_rd;
  logic                 dec_ecall;
  logic                 dec_ebreak;
  logic                 ex_redirect;
  logic                 halt_req;
  logic                 resume;
  logic                 fetch_req;
  logic                 ir_we;
  logic                 dec_en;
  logic                 ex_en;
  logic                 mem_req;
  logic                 mem_we;
  logic                 rf_we;
  logic                 pc_we;
  logic [1:0]           pc_sel;
  logic                 trap;
  logic [1:0]           trap_cause;
  logic                 halted;
  logic [CNT_WIDTH-1:0] instret;

  modport master (
    input  mem_ready, dec_illegal, dec_load, dec_store, dec_has_rd,
           dec_ecall, dec_ebreak, ex_redirect, halt_req, resume,
    output fetch_req, ir_we, dec_en, ex_en, mem_req, mem_we, rf_we,
           pc_we, pc_sel, trap, trap_cause, halted, instret
  );

  modport slave (
    output mem_ready, dec_illegal, dec_load, dec_store, dec_has_rd,
           dec_ecall, dec_ebreak, ex_redirect, halt_req, resume,
    input  fetch_req, ir_we, dec_en, ex_en, mem_req, mem_we, rf_we,
           pc_we, pc_sel, trap, trap_cause, halted, instret
  );
endinterface

// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - multi-cycle fetch/decode/execute/memory/writeback control FSM
module core_sequencer #(
  parameter int MEM_TIMEOUT  = 255,
  parameter bit HALT_ON_TRAP = 1'b1,
  parameter int CNT_WIDTH    = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  core_sequencer_if.master   bus
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_TRAP, S_HALT
  } state_t;

  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t               state, state_next;
  logic [WAIT_W-1:0]    wait_cnt;
  logic [CNT_WIDTH-1:0] instret_q;
  logic [1:0]           cause_q, cause_next;
  logic                 timeout;

  logic fetch_req, ir_we, dec_en, ex_en, mem_req, mem_we, rf_we, pc_we, trap, halted;
  logic [1:0] pc_sel;

  // The last waited cycle without mem_ready is the one that trips the trap.
  assign timeout = (MEM_TIMEOUT != 0) && !bus.mem_ready && (wait_cnt == WAIT_LAST);

  always_comb begin
    state_next = state;
    cause_next = cause_q;
    fetch_req  = 1'b0;
    ir_we      = 1'b0;
    dec_en     = 1'b0;
    ex_en      = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    rf_we      = 1'b0;
    pc_we      = 1'b0;
    pc_sel     = 2'b00;
    trap       = 1'b0;
    halted     = 1'b0;
    case (state)
      S_FETCH: begin
        fetch_req = 1'b1;
        if (bus.mem_ready) begin
          ir_we      = 1'b1;
          state_next = S_DECODE;
        end else if (timeout) begin
          state_next = S_TRAP;
          cause_next = 2'd3;
        end
      end
      S_DECODE: begin
        dec_en = 1'b1;
        if (bus.dec_illegal) begin
          state_next = S_TRAP;
          cause_next = 2'd0;
        end else begin
          state_next = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        ex_en = 1'b1;
        if (bus.dec_ecall) begin
          state_next = S_TRAP;
          cause_next = 2'd1;
        end else if (bus.dec_ebreak) begin
          state_next = S_TRAP;
          cause_next = 2'd2;
        end else if (bus.dec_load || bus.dec_store) begin
          state_next = S_MEMORY;
        end else begin
          state_next = S_WRITEBACK;
        end
      end
      S_MEMORY: begin
        mem_req = 1'b1;
        mem_we  = bus.dec_store;
        if (bus.mem_ready) begin
          state_next = S_WRITEBACK;
        end else if (timeout) begin
          state_next = S_TRAP;
          cause_next = 2'd3;
        end
      end
      S_WRITEBACK: begin
        rf_we      = bus.dec_has_rd && !bus.dec_store;
        pc_we      = 1'b1;
        pc_sel     = bus.ex_redirect ? 2'b01 : 2'b00;
        state_next = bus.halt_req ? S_HALT : S_FETCH;
      end
      S_TRAP: begin
        trap       = 1'b1;
        pc_we      = 1'b1;
        pc_sel     = 2'b10;
        state_next = HALT_ON_TRAP ? S_HALT : S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
        if (bus.resume) state_next = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      wait_cnt  <= '0;
      instret_q <= '0;
      cause_q   <= 2'd0;
    end else begin
      state <= state_next;
      if (state_next == S_TRAP) cause_q <= cause_next;
      // Staying in a wait state implies mem_ready was low; any state change restarts the count.
      if ((state == S_FETCH || state == S_MEMORY) && state_next == state)
        wait_cnt <= wait_cnt + 1'b1;
      else
        wait_cnt <= '0;
      if (state == S_WRITEBACK) instret_q <= instret_q + 1'b1;
    end
  end

  assign bus.fetch_req  = fetch_req;
  assign bus.ir_we      = ir_we;
  assign bus.dec_en     = dec_en;
  assign bus.ex_en      = ex_en;
  assign bus.mem_req    = mem_req;
  assign bus.mem_we     = mem_we;
  assign bus.rf_we      = rf_we;
  assign bus.pc_we      = pc_we;
  assign bus.pc_sel     = pc_sel;
  assign bus.trap       = trap;
  assign bus.trap_cause = cause_q;
  assign bus.halted     = halted;
  assign bus.instret    = instret_q;

endmodule

// File: tb/tb_core_sequencer.sv
// tb/tb_core_sequencer.sv - directed-vector bench for core_sequencer
module tb_core_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_bad = 0;

  core_sequencer_if #(.CNT_WIDTH(32)) bus ();

  core_sequencer #(
    .MEM_TIMEOUT (4),
    .HALT_ON_TRAP(1'b1),
    .CNT_WIDTH   (32)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // {fetch_req, ir_we, dec_en, ex_en, mem_req, mem_we, rf_we, pc_we, pc_sel, trap, halted}
  localparam logic [11:0] F_WAIT  = 12'b1_0_0_0_0_0_0_0_00_0_0;
  localparam logic [11:0] F_RDY   = 12'b1_1_0_0_0_0_0_0_00_0_0;
  localparam logic [11:0] DEC     = 12'b0_0_1_0_0_0_0_0_00_0_0;
  localparam logic [11:0] EXE     = 12'b0_0_0_1_0_0_0_0_00_0_0;
  localparam logic [11:0] MEM_RD  = 12'b0_0_0_0_1_0_0_0_00_0_0;
  localparam logic [11:0] MEM_WR  = 12'b0_0_0_0_1_1_0_0_00_0_0;
  localparam logic [11:0] WB_RD   = 12'b0_0_0_0_0_0_1_1_00_0_0;
  localparam logic [11:0] WB_NORD = 12'b0_0_0_0_0_0_0_1_00_0_0;
  localparam logic [11:0] WB_BR   = 12'b0_0_0_0_0_0_0_1_01_0_0;
  localparam logic [11:0] TRAPV   = 12'b0_0_0_0_0_0_0_1_10_1_0;
  localparam logic [11:0] HALTV   = 12'b0_0_0_0_0_0_0_0_00_0_1;

  function automatic logic [11:0] strobes();
    return {bus.fetch_req, bus.ir_we, bus.dec_en, bus.ex_en, bus.mem_req, bus.mem_we,
            bus.rf_we, bus.pc_we, bus.pc_sel, bus.trap, bus.halted};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dec(input logic il, input logic ld, input logic st, input logic rd,
                         input logic ec, input logic eb, input logic redir);
    bus.dec_illegal = il;
    bus.dec_load    = ld;
    bus.dec_store   = st;
    bus.dec_has_rd  = rd;
    bus.dec_ecall   = ec;
    bus.dec_ebreak  = eb;
    bus.ex_redirect = redir;
  endtask

  task automatic fetch_dec(input string tag);
    bus.mem_ready = 1'b1;
    #1 check_eq({tag, "_fetch"}, 64'(strobes()), 64'(F_RDY));
    tick();
    bus.mem_ready = 1'b0;
    #1 check_eq({tag, "_decode"}, 64'(strobes()), 64'(DEC));
    tick();
  endtask

  task automatic resume_pulse(input string tag);
    bus.resume = 1'b1;
    tick();
    bus.resume = 1'b0;
    #1 check_eq({tag, "_resumed"}, 64'(strobes()), 64'(F_WAIT));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n         = 1'b0;
    bus.mem_ready = 1'b0;
    bus.halt_req  = 1'b0;
    bus.resume    = 1'b0;
    set_dec(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_strobes", 64'(strobes()), 64'(F_WAIT));
    check_eq("rst_instret", 64'(bus.instret), 64'd0);
    check_eq("rst_cause", 64'(bus.trap_cause), 64'd0);
    rst_n = 1'b1;
    tick();

    // add: F, D, E, WB in four cycles
    set_dec(0, 0, 0, 1, 0, 0, 0);
    fetch_dec("alu");
    #1 check_eq("alu_exec", 64'(strobes()), 64'(EXE));
    tick();
    #1 check_eq("alu_wb", 64'(strobes()), 64'(WB_RD));
    check_eq("alu_instret_pre", 64'(bus.instret), 64'd0);
    tick();
    #1 check_eq("alu_instret", 64'(bus.instret), 64'd1);
    check_eq("alu_next_fetch", 64'(strobes()), 64'(F_WAIT));
    tick();

    // lw with two not-ready memory cycles
    set_dec(0, 1, 0, 1, 0, 0, 0);
    fetch_dec("lw");
    #1 check_eq("lw_exec", 64'(strobes()), 64'(EXE));
    tick();
    #1 check_eq("lw_mem1", 64'(strobes()), 64'(MEM_RD));
    tick();
    #1 check_eq("lw_mem2", 64'(strobes()), 64'(MEM_RD));
    tick();
    bus.mem_ready = 1'b1;
    #1 check_eq("lw_mem3", 64'(strobes()), 64'(MEM_RD));
    tick();
    bus.mem_ready = 1'b0;
    #1 check_eq("lw_wb", 64'(strobes()), 64'(WB_RD));
    tick();
    #1 check_eq("lw_instret", 64'(bus.instret), 64'd2);
    tick();

    // sw, same timing
    set_dec(0, 0, 1, 0, 0, 0, 0);
    fetch_dec("sw");
    #1 check_eq("sw_exec", 64'(strobes()), 64'(EXE));
    tick();
    #1 check_eq("sw_mem1", 64'(strobes()), 64'(MEM_WR));
    tick();
    #1 check_eq("sw_mem2", 64'(strobes()), 64'(MEM_WR));
    tick();
    bus.mem_ready = 1'b1;
    #1 check_eq("sw_mem3", 64'(strobes()), 64'(MEM_WR));
    tick();
    bus.mem_ready = 1'b0;
    #1 check_eq("sw_wb", 64'(strobes()), 64'(WB_NORD));
    tick();
    #1 check_eq("sw_instret", 64'(bus.instret), 64'd3);
    tick();

    // taken beq
    set_dec(0, 0, 0, 0, 0, 0, 1);
    fetch_dec("beq");
    #1 check_eq("beq_exec", 64'(strobes()), 64'(EXE));
    tick();
    #1 check_eq("beq_wb", 64'(strobes()), 64'(WB_BR));
    tick();
    #1 check_eq("beq_instret", 64'(bus.instret), 64'd4);
    tick();

    // illegal instruction trap, halt, resume
    set_dec(1, 0, 0, 1, 0, 0, 0);
    fetch_dec("ill");
    #1 check_eq("ill_trap", 64'(strobes()), 64'(TRAPV));
    check_eq("ill_cause", 64'(bus.trap_cause), 64'd0);
    tick();
    #1 check_eq("ill_halt", 64'(strobes()), 64'(HALTV));
    tick();
    bus.halt_req = 1'b1;
    #1 check_eq("ill_halt_hold", 64'(strobes()), 64'(HALTV));
    check_eq("ill_instret", 64'(bus.instret), 64'd4);
    bus.halt_req = 1'b0;
    resume_pulse("ill");

    // ebreak outranks a memory op
    set_dec(0, 1, 0, 1, 0, 1, 0);
    fetch_dec("ebrk");
    #1 check_eq("ebrk_exec", 64'(strobes()), 64'(EXE));
    tick();
    #1 check_eq("ebrk_trap", 64'(strobes()), 64'(TRAPV));
    check_eq("ebrk_cause", 64'(bus.trap_cause), 64'd2);
    tick();
    resume_pulse("ebrk");

    // memory timeout: four not-ready cycles then trap cause 3
    set_dec(0, 1, 0, 1, 0, 0, 0);
    fetch_dec("tmo");
    #1 check_eq("tmo_exec", 64'(strobes()), 64'(EXE));
    tick();
    for (int i = 0; i < 4; i++) begin
      #1 check_eq($sformatf("tmo_mem%0d", i + 1), 64'(strobes()), 64'(MEM_RD));
      tick();
    end
    #1 check_eq("tmo_trap", 64'(strobes()), 64'(TRAPV));
    check_eq("tmo_cause", 64'(bus.trap_cause), 64'd3);
    tick();
    #1 check_eq("tmo_halt", 64'(strobes()), 64'(HALTV));
    check_eq("tmo_cause_held", 64'(bus.trap_cause), 64'd3);
    check_eq("tmo_instret", 64'(bus.instret), 64'd4);
    resume_pulse("tmo");

    // mem_ready on the limit cycle completes instead of trapping
    fetch_dec("lim");
    #1 check_eq("lim_exec", 64'(strobes()), 64'(EXE));
    tick();
    for (int i = 0; i < 3; i++) begin
      #1 check_eq($sformatf("lim_mem%0d", i + 1), 64'(strobes()), 64'(MEM_RD));
      tick();
    end
    bus.mem_ready = 1'b1;
    #1 check_eq("lim_mem4", 64'(strobes()), 64'(MEM_RD));
    tick();
    bus.mem_ready = 1'b0;
    #1 check_eq("lim_wb", 64'(strobes()), 64'(WB_RD));
    tick();
    #1 check_eq("lim_instret", 64'(bus.instret), 64'd5);
    tick();

    // asynchronous reset in the middle of MEMORY
    fetch_dec("rstm");
    #1 check_eq("rstm_exec", 64'(strobes()), 64'(EXE));
    tick();
    #1 check_eq("rstm_mem", 64'(strobes()), 64'(MEM_RD));
    check_eq("rstm_instret_pre", 64'(bus.instret), 64'd5);
    tick();
    rst_n = 1'b0;
    #1 check_eq("rstm_strobes", 64'(strobes()), 64'(F_WAIT));
    check_eq("rstm_mem_req", 64'(bus.mem_req), 64'd0);
    check_eq("rstm_instret", 64'(bus.instret), 64'd0);
    check_eq("rstm_cause", 64'(bus.trap_cause), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // halt_req during EXECUTE lets the instruction retire first
    set_dec(0, 0, 0, 1, 0, 0, 0);
    fetch_dec("hreq");
    bus.halt_req = 1'b1;
    #1 check_eq("hreq_exec", 64'(strobes()), 64'(EXE));
    tick();
    #1 check_eq("hreq_wb", 64'(strobes()), 64'(WB_RD));
    tick();
    bus.halt_req = 1'b0;
    #1 check_eq("hreq_halt", 64'(strobes()), 64'(HALTV));
    check_eq("hreq_instret", 64'(bus.instret), 64'd1);
    resume_pulse("hreq");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
Multi-cycle control FSM that sequences the core datapath: instruction fetch, decode, execute, memory access, and writeback/PC update.
- Drives the enable strobes into the fetch, decode, execute, register-file and PC blocks.
- Owns the single memory request/ready handshake.
- Handles traps (illegal, ecall, ebreak, bus timeout), halt and resume.
- Keeps a retired-instruction counter.

Parameters:
MEM_TIMEOUT, 255, max wait cycles for mem_ready per request; 0 disables the timeout
HALT_ON_TRAP, 1, 1: TRAP goes to HALT; 0: TRAP goes to FETCH
CNT_WIDTH, 32, width of instret

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
mem_ready  in  1  memory completes current request this cycle
dec_illegal  in  1  decoded instruction is illegal
dec_load  in  1  instruction is lb/lh/lw/lbu/lhu
dec_store  in  1  instruction is sb/sh/sw
dec_has_rd  in  1  instruction writes rd
dec_ecall  in  1  ecall
dec_ebreak  in  1  ebreak
ex_redirect  in  1  taken branch or jal/jalr
halt_req  in  1  request halt at next instruction boundary
resume  in  1  leave HALT
fetch_req  out  1  instruction fetch request
ir_we  out  1  latch fetched instruction
dec_en  out  1  decode strobe
ex_en  out  1  execute strobe
mem_req  out  1  data memory request
mem_we  out  1  data request is a write
rf_we  out  1  register file write
pc_we  out  1  PC update
pc_sel  out  2  00 pc+4, 01 redirect target, 10 trap vector
trap  out  1  trap taken this cycle
trap_cause  out  2  0 illegal, 1 ecall, 2 ebreak, 3 bus timeout (held until next trap)
halted  out  1  FSM in HALT
instret  out  CNT_WIDTH  retired instruction count

Behaviour:
- All state and the counters reset asynchronously on rst_n low.
  - Reset state is FETCH.
  - instret=0, trap_cause=0, wait counter=0.
- Reset mid-operation aborts the request immediately; there is no completion.
- States: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, TRAP, HALT.
- Strobes are decoded combinationally from the state register plus the listed inputs. Every strobe is 0 in states not listed below.
- FETCH:
  - fetch_req=1.
  - On mem_ready: ir_we=1 in the same cycle, next state DECODE.
- DECODE:
  - dec_en=1 for one cycle.
  - dec_illegal -> TRAP with cause 0; else -> EXECUTE.
- EXECUTE:
  - ex_en=1 for one cycle.
  - Transition priority: dec_ecall -> TRAP cause 1; dec_ebreak -> TRAP cause 2; dec_load|dec_store -> MEMORY; else -> WRITEBACK.
- MEMORY:
  - mem_req=1, mem_we=dec_store; mem_req holds until mem_ready.
  - On mem_ready -> WRITEBACK.
- WRITEBACK (one cycle):
  - rf_we=dec_has_rd & ~dec_store.
  - pc_we=1, pc_sel=ex_redirect ? 01 : 00.
  - instret increments and wraps at 2^CNT_WIDTH.
  - Next state: halt_req ? HALT : FETCH.
- TRAP (one cycle):
  - trap=1, pc_we=1, pc_sel=10; trap_cause updated on entry.
  - instret does not increment.
  - Next state: HALT_ON_TRAP ? HALT : FETCH.
- HALT:
  - halted=1.
  - resume -> FETCH; halt_req is ignored in HALT.
- Memory timeout (FETCH and MEMORY):
  - The wait counter clears on entering the state and increments each cycle mem_ready=0.
  - If MEM_TIMEOUT!=0 and the counter reaches MEM_TIMEOUT with mem_ready=0 -> TRAP cause 3; the request drops.
  - mem_ready in the same cycle as the limit wins (completion, no trap).
- mem_ready outside FETCH/MEMORY is ignored.
- halt_req is sampled only in WRITEBACK; it never aborts an instruction in flight.
- Decode inputs are assumed stable from DECODE through WRITEBACK; the instruction register holds them.

Test Plan:
- ALU op (add), mem_ready=1 in the first FETCH cycle -> FETCH, DECODE, EXECUTE, WRITEBACK in 4 cycles; rf_we=1 and pc_sel=00 in WRITEBACK; instret 0->1.
- lw with mem_ready low for 2 MEMORY cycles -> mem_req high 3 cycles, mem_we=0, WRITEBACK at cycle 7, rf_we=1; sw same sequence with mem_we=1 and rf_we=0.
- Taken beq (dec_has_rd=0, ex_redirect=1) -> WRITEBACK with pc_we=1, pc_sel=01, rf_we=0; instret increments.
- dec_illegal in DECODE -> TRAP next cycle: trap=1, pc_sel=10, trap_cause=0, then halted=1 (HALT_ON_TRAP=1); resume pulse -> FETCH next cycle.
- MEM_TIMEOUT=4, mem_ready stuck low in MEMORY -> TRAP cause 3 after 4 wait cycles. Repeat with mem_ready=1 on the 4th wait cycle -> WRITEBACK, no trap.
- rst_n low mid-MEMORY with instret=5 -> immediately FETCH, mem_req=0, instret=0. halt_req during EXECUTE -> instruction retires, then HALT.
